video_capture: RTL and testbench

Sink-side counterpart of the video sync generator: samples an incoming hsync/vsync/pixel-enable/pixel stream, recovers pixel coordinates, measures the active frame size and locks onto it once several consecutive frames agree. While locked, it emits one linear-address frame-memory write per enabled pixel. It sits between an external video source, or the generator looped back for test, and the frame-buffer memory.

---
 rtl/video_capture.sv | 257 +++++++++++++++++++++++++
 tb/tb_video_capture.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_capture.sv
// video_capture: recovers pixel coordinates from an hsync/vsync/enable stream, locks
// onto a stable frame size and emits linear frame-memory writes. Optional vsync
// watchdog is enabled by defining VIDEO_CAPTURE_TIMEOUT_EN.
module video_capture #(
  parameter int   HPIX_MAX       = 1024,
  parameter int   VPIX_MAX       = 1024,
  parameter logic HSYNC_ACTIVE   = 1'b0,
  parameter logic VSYNC_ACTIVE   = 1'b0,
  parameter int   ADDR_BITS      = 20,
  parameter int   PIXEL_BITS     = 24,
  parameter int   LOCK_FRAMES    = 2,
  parameter int   TIMEOUT_CYCLES = 2000000,
  localparam int  HBITS          = $clog2(HPIX_MAX+1),
  localparam int  VBITS          = $clog2(VPIX_MAX+1)
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_hsync,
  input  logic                  in_vsync,
  input  logic                  in_pixel_enable,
  input  logic [PIXEL_BITS-1:0] in_pixel,
  output logic                  out_mem_wr,
  output logic [ADDR_BITS-1:0]  out_mem_addr,
  output logic [PIXEL_BITS-1:0] out_mem_data,
  output logic [HBITS-1:0]      out_hpix,
  output logic [VBITS-1:0]      out_vpix,
  output logic [HBITS-1:0]      out_width,
  output logic [VBITS-1:0]      out_height,
  output logic                  out_locked,
  output logic                  out_frame_start,
  output logic                  out_err
);
  localparam int MBITS  = $clog2(LOCK_FRAMES+1);
  localparam int STAGES = 1;

  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

  typedef struct packed {
    logic [ADDR_BITS-1:0]  addr;
    logic [PIXEL_BITS-1:0] data;
    logic [HBITS-1:0]      x;
    logic [VBITS-1:0]      y;
  } wreq_t;

  state_t state, state_n;

  logic                  hs_q, hs_p, vs_q, vs_p, pe_q;
  logic [PIXEL_BITS-1:0] px_q;
  logic                  hs_edge, vs_edge;

  logic [HBITS-1:0]      x_cnt, x_n, ref_len, ref_ln, pix_x;
  logic                  ref_vld, refv_ln;
  logic [VBITS-1:0]      y_cnt, y_ln, pix_y;
  logic                  bad, bad_ln, ovf, ln_close, pix_bad;
  logic [ADDR_BITS-1:0]  addr_cnt, pix_addr;
  logic                  wr_c;

  logic [MBITS-1:0]      match_cnt, match_n, m_inc;
  logic [HBITS-1:0]      prev_w, prev_w_n, lock_w_n;
  logic [VBITS-1:0]      prev_h, prev_h_n, lock_h_n;
  logic                  err_n, timeout;

  wreq_t                 req_c, req_a, req_o;
  logic [STAGES:0]       vld_pipe;

  // Input capture; sync history resets to the idle level so release is quiet.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      hs_q <= ~HSYNC_ACTIVE;
      hs_p <= ~HSYNC_ACTIVE;
      vs_q <= ~VSYNC_ACTIVE;
      vs_p <= ~VSYNC_ACTIVE;
      pe_q <= 1'b0;
      px_q <= '0;
    end else begin
      hs_q <= in_hsync;
      hs_p <= hs_q;
      vs_q <= in_vsync;
      vs_p <= vs_q;
      pe_q <= in_pixel_enable;
      px_q <= in_pixel;
    end
  end

  assign hs_edge = (hs_p != HSYNC_ACTIVE) && (hs_q == HSYNC_ACTIVE);
  assign vs_edge = (vs_p != VSYNC_ACTIVE) && (vs_q == VSYNC_ACTIVE);

  // Line end is resolved first; the *_ln values are what a coincident frame end sees.
  always_comb begin
    ln_close = hs_edge && (x_cnt != '0);
    ref_ln   = ref_len;
    refv_ln  = ref_vld;
    bad_ln   = bad;
    y_ln     = y_cnt;
    if (ln_close) begin
      if (!ref_vld) begin
        ref_ln  = x_cnt;
        refv_ln = 1'b1;
      end else if (x_cnt != ref_len) begin
        bad_ln = 1'b1;
      end
      if (y_cnt == VBITS'(VPIX_MAX)) bad_ln = 1'b1;
      else                           y_ln   = y_cnt + 1'b1;
    end

    pix_x = hs_edge ? '0 : x_cnt;
    ovf   = pe_q && (pix_x == HBITS'(HPIX_MAX));
    if (hs_edge)             x_n = HBITS'(pe_q);
    else if (pe_q && !ovf)   x_n = x_cnt + 1'b1;
    else                     x_n = x_cnt;

    pix_y    = vs_edge ? '0 : y_ln;
    pix_bad  = vs_edge ? ovf : (bad_ln | ovf);
    pix_addr = vs_edge ? '0 : addr_cnt;
    wr_c     = (state == LOCKED) && pe_q && !pix_bad &&
               (pix_x < out_width) && (pix_y < out_height);
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      bad      <= 1'b0;
      ref_len  <= '0;
      ref_vld  <= 1'b0;
      addr_cnt <= '0;
    end else begin
      x_cnt    <= x_n;
      addr_cnt <= wr_c ? pix_addr + 1'b1 : pix_addr;
      if (vs_edge) begin
        y_cnt   <= '0;
        bad     <= ovf;
        ref_len <= '0;
        ref_vld <= 1'b0;
      end else begin
        y_cnt   <= y_ln;
        bad     <= bad_ln | ovf;
        ref_len <= ref_ln;
        ref_vld <= refv_ln;
      end
    end
  end

`ifdef VIDEO_CAPTURE_TIMEOUT_EN
  localparam int WBITS = $clog2(TIMEOUT_CYCLES+1);
  logic [WBITS-1:0] wd_cnt;

  // Only armed once a format is being tracked; SEARCH waits quietly.
  assign timeout = (state != SEARCH) && !vs_edge && (wd_cnt == WBITS'(TIMEOUT_CYCLES-1));

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst)                                      wd_cnt <= '0;
    else if (vs_edge || timeout || state == SEARCH)   wd_cnt <= '0;
    else                                              wd_cnt <= wd_cnt + 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    match_n  = match_cnt;
    prev_w_n = prev_w;
    prev_h_n = prev_h;
    lock_w_n = out_width;
    lock_h_n = out_height;
    err_n    = 1'b0;
    m_inc    = ((match_cnt != '0) && (ref_ln == prev_w) && (y_ln == prev_h)) ?
               match_cnt + 1'b1 : MBITS'(1);
    if (vs_edge) begin
      case (state)
        SEARCH: begin
          state_n = MEASURE;
          match_n = '0;
        end
        MEASURE: begin
          if (bad_ln) begin
            err_n   = 1'b1;
            match_n = '0;
          end else if (y_ln != '0) begin
            match_n  = m_inc;
            prev_w_n = ref_ln;
            prev_h_n = y_ln;
            if (m_inc >= MBITS'(LOCK_FRAMES)) begin
              state_n  = LOCKED;
              lock_w_n = ref_ln;
              lock_h_n = y_ln;
            end
          end
        end
        LOCKED: begin
          if (bad_ln || (ref_ln != out_width) || (y_ln != out_height)) begin
            err_n   = 1'b1;
            state_n = MEASURE;
            match_n = '0;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
    if (timeout) begin
      state_n = SEARCH;
      err_n   = 1'b1;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) state <= SEARCH;
    else         state <= state_n;
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      match_cnt       <= '0;
      prev_w          <= '0;
      prev_h          <= '0;
      out_width       <= '0;
      out_height      <= '0;
      out_err         <= 1'b0;
      out_locked      <= 1'b0;
      out_frame_start <= 1'b0;
    end else begin
      match_cnt       <= match_n;
      prev_w          <= prev_w_n;
      prev_h          <= prev_h_n;
      out_width       <= lock_w_n;
      out_height      <= lock_h_n;
      out_err         <= err_n;
      out_locked      <= (state_n == LOCKED);
      out_frame_start <= vs_edge;
    end
  end

  // Two register stages from the captured pixel to the memory port.
  assign req_c = '{addr: pix_addr, data: px_q, x: pix_x, y: pix_y};

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      vld_pipe <= '0;
      req_a    <= '0;
      req_o    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], wr_c};
      if (wr_c)        req_a <= req_c;
      if (vld_pipe[0]) req_o <= req_a;
    end
  end

  assign out_mem_wr   = vld_pipe[STAGES];
  assign out_mem_addr = req_o.addr;
  assign out_mem_data = req_o.data;
  assign out_hpix     = req_o.x;
  assign out_vpix     = req_o.y;

endmodule

// File: tb/tb_video_capture.sv
// Directed bench for video_capture: a small sync generator drives frames, expected
// writes go to a scoreboard queue and a monitor pops them as the DUT writes.
module tb_video_capture;
  localparam int HB = $clog2(1024+1);
  localparam int VB = $clog2(1024+1);
  localparam int AB = 20;
  localparam int PB = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hs  = 1'b1;
  logic          vs  = 1'b1;
  logic          pe  = 1'b0;
  logic [PB-1:0] px  = '0;

  logic          wr, locked, fstart, err;
  logic [AB-1:0] addr;
  logic [PB-1:0] data;
  logic [HB-1:0] hpix, width;
  logic [VB-1:0] vpix, height;

  video_capture #(.LOCK_FRAMES(2), .TIMEOUT_CYCLES(100)) dut (
    .in_clk(clk), .in_rst(rst), .in_hsync(hs), .in_vsync(vs),
    .in_pixel_enable(pe), .in_pixel(px),
    .out_mem_wr(wr), .out_mem_addr(addr), .out_mem_data(data),
    .out_hpix(hpix), .out_vpix(vpix), .out_width(width), .out_height(height),
    .out_locked(locked), .out_frame_start(fstart), .out_err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AB-1:0] addr;
    logic [PB-1:0] data;
    logic [HB-1:0] x;
    logic [VB-1:0] y;
  } wr_t;

  wr_t exp_q[$];
  int  vectors = 0, miscompares = 0;
  int  err_seen = 0, fs_seen = 0, vs_sent = 0, exp_err = 0, e0 = 0;
  int  lock_w = 4, lock_h = 4;

  task automatic chk(string name, longint act, longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    wr_t e;
    if (rst) begin
      if (err)    err_seen++;
      if (fstart) fs_seen++;
      if (wr) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_wr: got addr %0d data %0h, want no write", addr, data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", addr, e.addr);
          chk("wr_data", data, e.data);
          chk("wr_hpix", hpix, e.x);
          chk("wr_vpix", vpix, e.y);
        end
      end
    end
  end

  task automatic cyc(logic h, logic v, logic p, logic [PB-1:0] d);
    @(negedge clk);
    hs = h; vs = v; pe = p; px = d;
  endtask

  task automatic send_vsync(bit with_hs);
    vs_sent++;
    cyc(with_hs ? 1'b0 : 1'b1, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, '0);
  endtask

  task automatic send_line(int y, int n, bit close, bit wr_en);
    for (int x = 0; x < n; x++) begin
      cyc(1'b1, 1'b1, 1'b1, {12'(y), 12'(x)});
      if (wr_en && x < lock_w && y < lock_h)
        exp_q.push_back('{AB'(y*lock_w + x), {12'(y), 12'(x)}, HB'(x), VB'(y)});
    end
    repeat (2) cyc(1'b1, 1'b1, 1'b0, '0);
    if (close) begin
      repeat (2) cyc(1'b0, 1'b1, 1'b0, '0);
      repeat (2) cyc(1'b1, 1'b1, 1'b0, '0);
    end
  endtask

  task automatic send_body(int w, int h, bit wr_en, int bad_line, int bad_len, bit hv);
    for (int y = 0; y < h; y++)
      send_line(y, (y == bad_line) ? bad_len : w, !(hv && y == h-1),
                wr_en && (bad_line < 0 || y <= bad_line));
  endtask

  task automatic pulse_reset(bit check);
    @(negedge clk);
    rst = 1'b0; hs = 1'b1; vs = 1'b1; pe = 1'b0; px = '0;
    #1;
    if (check) begin
      chk("rst_mid_locked", locked, 0);
      chk("rst_mid_wr", wr, 0);
      chk("rst_mid_addr", addr, 0);
      chk("rst_mid_width", width, 0);
      chk("rst_mid_height", height, 0);
      chk("rst_mid_hpix", hpix, 0);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_watchdog: got no finish, want finish within budget");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_wr", wr, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_fstart", fstart, 0);
    chk("rst_width", width, 0);
    chk("rst_height", height, 0);
    chk("rst_addr", addr, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) cyc(1'b1, 1'b1, 1'b0, '0);

    // Lock on 4x4, third frame written
    send_vsync(0); send_body(4, 4, 0, -1, 0, 0);
    send_vsync(0); send_body(4, 4, 0, -1, 0, 0);
    chk("unlocked_f2", locked, 0);
    send_vsync(0);
    chk("locked_f3", locked, 1);
    chk("width_f3", width, 4);
    chk("height_f3", height, 4);
    send_body(4, 4, 1, -1, 0, 0);

    // Wider frame while locked: only x<4 is written, error at its end
    send_vsync(0); send_body(5, 4, 1, -1, 0, 0);
    e0 = err_seen;
    send_vsync(0);
    exp_err++;
    chk("err_wide", err_seen - e0, 1);
    chk("unlock_wide", locked, 0);
    send_body(4, 4, 0, -1, 0, 0);
    send_vsync(0); send_body(4, 4, 0, -1, 0, 0);
    chk("relock_pending", locked, 0);
    send_vsync(0);
    chk("relock_wide", locked, 1);
    chk("err_wide_once", err_seen - e0, 1);
    send_body(4, 4, 1, -1, 0, 0);

    // Short second line: writes stop after it, error at next vsync
    send_vsync(0); send_body(4, 4, 1, 1, 3, 0);
    e0 = err_seen;
    send_vsync(0);
    exp_err++;
    chk("err_short", err_seen - e0, 1);
    chk("unlock_short", locked, 0);
    send_body(4, 4, 0, -1, 0, 0);
    send_vsync(0); send_body(4, 4, 0, -1, 0, 0);
    send_vsync(0);
    chk("relock_short", locked, 1);

    // Reset mid-frame while locked
    send_line(0, 4, 1, 1);
    chk("drained_before_rst", exp_q.size(), 0);
    pulse_reset(1);
    for (int y = 1; y < 4; y++) send_line(y, 4, 1, 0);
    send_vsync(0); send_body(4, 4, 0, -1, 0, 0);
    send_vsync(0); send_body(4, 4, 0, -1, 0, 0);
    chk("rst_relock_pending", locked, 0);
    send_vsync(0);
    chk("rst_relock", locked, 1);
    send_body(4, 4, 1, -1, 0, 0);

    // Final line closed by an hsync edge coincident with vsync
    pulse_reset(0);
    send_vsync(0); send_body(4, 4, 0, -1, 0, 1);
    send_vsync(1); send_body(4, 4, 0, -1, 0, 1);
    send_vsync(1);
    chk("hv_locked", locked, 1);
    chk("hv_height", height, 4);
    chk("hv_width", width, 4);
    send_body(4, 4, 1, -1, 0, 1);
    e0 = err_seen;
    send_vsync(1);
    chk("hv_no_err", err_seen - e0, 0);
    chk("hv_still_locked", locked, 1);

`ifdef VIDEO_CAPTURE_TIMEOUT_EN
    e0 = err_seen;
    repeat (150) cyc(1'b1, 1'b1, 1'b0, '0);
    exp_err++;
    chk("timeout_err", err_seen - e0, 1);
    chk("timeout_unlock", locked, 0);
    repeat (250) cyc(1'b1, 1'b1, 1'b0, '0);
    chk("timeout_search_quiet", err_seen - e0, 1);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("frame_start_count", fs_seen, vs_sent);
    chk("err_total", err_seen, exp_err);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
